cim_seq_ctrl: RTL and testbench

//  Top-level sequencer for one digital CIM macro. Runs a job of 1..2^VEC_W activation vectors: per vector

---
 rtl/cim_pkg.sv | 33 +++
 rtl/cim_slice_cnt.sv | 41 ++++
 rtl/cim_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cim_seq_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
`default_nettype none
// Shared state encoding, input-precision codes and slice-count lookup for the CIM sequencer.
package cim_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_ACT = 3'd1,
        S_COMPUTE  = 3'd2,
        S_DRAIN    = 3'd3,
        S_OUT      = 3'd4
    } state_t;

    localparam logic [1:0] INW_8B   = 2'b00;
    localparam logic [1:0] INW_12B  = 2'b01;
    localparam logic [1:0] INW_16B  = 2'b10;
    localparam logic [1:0] INW_RSVD = 2'b11;

    localparam int SEL_W = 4;

    // Index of the last bit-slice for a given precision; the reserved code falls back to 8b.
    function automatic logic [SEL_W-1:0] slice_count(input logic [1:0] inwidth);
        logic [SEL_W-1:0] c;
        case (inwidth)
            INW_8B:   c = 4'd7;
            INW_12B:  c = 4'd11;
            INW_16B:  c = 4'd15;
            INW_RSVD: c = 4'd7;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cim_slice_cnt.sv
`default_nettype none
// Bit-slice select counter: counts 0..count_i while enabled, wraps to 0, flags first/last slice.
module cim_slice_cnt
    import cim_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [SEL_W-1:0] count_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             st_o,
    output logic             lst_o
);

    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;

    always_comb begin
        sel_d = sel_q;
        if (clr_i) begin
            sel_d = '0;
        end else if (en_i) begin
            sel_d = (sel_q == count_i) ? '0 : sel_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign sel_o = sel_q;
    assign st_o  = en_i & (sel_q == '0);
    assign lst_o = en_i & (sel_q == count_i);

endmodule
`default_nettype wire

// File: rtl/cim_seq_ctrl.sv
`default_nettype none
// Job sequencer for one digital CIM macro: pop vector, step bit slices, drain adder tree, hand off result.
// Optional macro CIM_SIGNED_EN adds signed_mode / msb_neg for two's-complement activations.
module cim_seq_ctrl
    import cim_pkg::*;
#(
    parameter int PIPE_LAT = 3,
    parameter int VEC_W    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       inwidth,
    input  logic [VEC_W-1:0] nvec,
    input  logic             act_valid,
    output logic             act_pop,
    output logic [3:0]       sel,
    output logic             st,
    output logic             lst,
    output logic             acc_en,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             done
`ifdef CIM_SIGNED_EN
    ,
    input  logic             signed_mode,
    output logic             msb_neg
`endif
);

    localparam logic [3:0] DRAIN_INIT = 4'(PIPE_LAT - 1);

    state_t           state_q,   state_d;
    logic [SEL_W-1:0] count_q,   count_d;
    logic [VEC_W-1:0] nvec_q,    nvec_d;
    logic [VEC_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [3:0]       drain_q,   drain_d;
    logic             done_q,    done_d;

    logic             w_compute;
    logic             w_lst;

    assign w_compute = (state_q == S_COMPUTE);

    cim_slice_cnt u_slice_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .clr_i   (abort | ~w_compute),
        .en_i    (w_compute),
        .count_i (count_q),
        .sel_o   (sel),
        .st_o    (st),
        .lst_o   (w_lst)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        nvec_d    = nvec_q;
        vec_cnt_d = vec_cnt_q;
        drain_d   = drain_q;
        done_d    = 1'b0;
        act_pop   = 1'b0;
        res_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_WAIT_ACT;
                    count_d   = slice_count(inwidth);
                    nvec_d    = nvec;
                    vec_cnt_d = '0;
                end
            end
            S_WAIT_ACT: begin
                if (act_valid) begin
                    act_pop = 1'b1;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (w_lst) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_OUT;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    // Compare before incrementing so an all-ones nvec runs the full 2^VEC_W vectors.
                    if (vec_cnt_q == nvec_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        vec_cnt_d = vec_cnt_q + 1'b1;
                        state_d   = S_WAIT_ACT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Cancel overrides everything; suppress the pop so no vector is consumed without compute.
        if (abort) begin
            state_d   = S_IDLE;
            vec_cnt_d = '0;
            drain_d   = '0;
            done_d    = 1'b0;
            act_pop   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            nvec_q    <= '0;
            vec_cnt_q <= '0;
            drain_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            nvec_q    <= nvec_d;
            vec_cnt_q <= vec_cnt_d;
            drain_q   <= drain_d;
            done_q    <= done_d;
        end
    end

    assign lst    = w_lst;
    assign acc_en = w_compute;
    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;

`ifdef CIM_SIGNED_EN
    logic signed_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            signed_q <= 1'b0;
        end else if (state_q == S_IDLE && start && !abort) begin
            signed_q <= signed_mode;
        end
    end

    assign msb_neg = w_lst & signed_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cim_seq_ctrl.sv
`default_nettype none
// Bench for cim_seq_ctrl: job table, directed corner sequences, random traffic against a slot-position model.
module tb_cim_seq_ctrl;

    localparam int PIPE_LAT = 3;
    localparam int VEC_W    = 8;

    logic             clk = 1'b0;
    logic             rstn, start, abort, act_valid, res_ready;
    logic [1:0]       inwidth;
    logic [VEC_W-1:0] nvec;
    logic             act_pop, st, lst, acc_en, res_valid, busy, done;
    logic [3:0]       sel;
`ifdef CIM_SIGNED_EN
    logic             signed_mode, msb_neg;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cim_seq_ctrl #(.PIPE_LAT(PIPE_LAT), .VEC_W(VEC_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .abort     (abort),
        .inwidth   (inwidth),
        .nvec      (nvec),
        .act_valid (act_valid),
        .act_pop   (act_pop),
        .sel       (sel),
        .st        (st),
        .lst       (lst),
        .acc_en    (acc_en),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done)
`ifdef CIM_SIGNED_EN
        ,
        .signed_mode (signed_mode),
        .msb_neg     (msb_neg)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: a job is a series of vectors; each vector occupies slot positions
    // 0 (waiting for data), 1..S (slices), S+1..S+PIPE_LAT (drain), S+PIPE_LAT+1 (result offered).
    bit   mon_en = 0;
    bit   m_job = 0, m_done = 0, m_sgn = 0;
    int   m_pos = 0, m_vec = 0, m_nv = 0, m_cnt = 7;
    int   m_S, m_outp;
    logic [11:0] m_exp, m_act;
    logic        e_pop, e_st, e_lst, e_acc, e_rv, e_neg;
    logic [3:0]  e_sel;

    always @(negedge clk) begin
        m_S    = m_cnt + 1;
        m_outp = m_S + PIPE_LAT + 1;
        e_pop = 0; e_st = 0; e_lst = 0; e_acc = 0; e_rv = 0; e_sel = 4'd0;
        if (m_job) begin
            if (m_pos == 0) begin
                e_pop = act_valid & ~abort;
            end else if (m_pos <= m_S) begin
                e_sel = 4'(m_pos - 1);
                e_st  = (m_pos == 1);
                e_lst = (m_pos == m_S);
                e_acc = 1;
            end else if (m_pos == m_outp) begin
                e_rv = 1;
            end
        end
        e_neg = e_lst & m_sgn;
        m_exp = {e_pop, e_sel, e_st, e_lst, e_acc, e_rv, m_job, m_done, e_neg};
`ifdef CIM_SIGNED_EN
        m_act = {act_pop, sel, st, lst, acc_en, res_valid, busy, done, msb_neg};
`else
        m_act = {act_pop, sel, st, lst, acc_en, res_valid, busy, done, 1'b0};
`endif
        if (mon_en) chk("model", 32'(m_act), 32'(m_exp));

        m_done = 0;
        if (!rstn || abort) begin
            m_job = 0;
            m_pos = 0;
        end else if (!m_job) begin
            if (start) begin
                m_job = 1; m_pos = 0; m_vec = 0; m_nv = int'(nvec);
                m_cnt = (inwidth == 2'b01) ? 11 : (inwidth == 2'b10) ? 15 : 7;
`ifdef CIM_SIGNED_EN
                m_sgn = signed_mode;
`endif
            end
        end else if (m_pos == 0) begin
            if (act_valid) m_pos = 1;
        end else if (m_pos < m_outp) begin
            m_pos++;
        end else if (res_ready) begin
            if (m_vec == m_nv) begin
                m_job = 0; m_done = 1;
            end else begin
                m_vec++; m_pos = 0;
            end
        end
    end

    task automatic wait_idle(input string nm);
        for (int n = 0; n < 2000 && busy; n++) cyc();
        chk(nm, 32'(busy), 0);
    endtask

    // Full job with data always available and results always accepted.
    task automatic run_job(input logic [1:0] inw, input logic [7:0] nv,
                           output int busy_n, output int pops, output int maxsel,
                           output int dones, output bit tmo);
        busy_n = 0; pops = 0; maxsel = 0; dones = 0; tmo = 1;
        act_valid = 1; res_ready = 1;
        inwidth = inw; nvec = nv; start = 1;
        cyc();
        start = 0;
        for (int n = 0; n < 20000; n++) begin
            inwidth = 2'($urandom);
            nvec    = 8'($urandom);
            #1;
            if (done) dones++;
            if (!busy) begin tmo = 0; break; end
            busy_n++;
            if (act_pop) pops++;
            if (int'(sel) > maxsel) maxsel = int'(sel);
            cyc();
        end
        cyc();
        if (done) dones++;
    endtask

    typedef struct {
        logic [1:0] inw;
        logic [7:0] nv;
        int         exp_maxsel;
        int         exp_pops;
        int         exp_busy;
    } job_vec_t;

    job_vec_t tbl[5];
    int  b_n, p_n, ms, d_n, t_st, t_lst, t_rv, t_done, cnt;
    bit  tmo;

    initial begin
        tbl[0] = '{2'b00, 8'd0,   7,  1,   13};
        tbl[1] = '{2'b01, 8'd0,   11, 1,   17};
        tbl[2] = '{2'b10, 8'd2,   15, 3,   63};
        tbl[3] = '{2'b11, 8'd1,   7,  2,   26};
        tbl[4] = '{2'b00, 8'hFF,  7,  256, 3328};

        rstn = 0; start = 0; abort = 0; act_valid = 0; res_ready = 0;
        inwidth = 0; nvec = 0;
`ifdef CIM_SIGNED_EN
        signed_mode = 0;
`endif
        cyc(); cyc();
        rstn = 1;
        mon_en = 1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_acc_en", 32'(acc_en), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_st_lst", 32'({st, lst}), 0);
        chk("rst_act_pop", 32'(act_pop), 0);

        for (int i = 0; i < 5; i++) begin
            run_job(tbl[i].inw, tbl[i].nv, b_n, p_n, ms, d_n, tmo);
            chk($sformatf("job%0d_timeout", i), 32'(tmo), 0);
            chk($sformatf("job%0d_busy_cycles", i), 32'(b_n), 32'(tbl[i].exp_busy));
            chk($sformatf("job%0d_pops", i), 32'(p_n), 32'(tbl[i].exp_pops));
            chk($sformatf("job%0d_max_sel", i), 32'(ms), 32'(tbl[i].exp_maxsel));
            chk($sformatf("job%0d_done_pulses", i), 32'(d_n), 1);
        end

        // 8b single vector: event timing relative to the WAIT_ACT cycle (index 0).
        t_st = -1; t_lst = -1; t_rv = -1; t_done = -1;
        act_valid = 1; res_ready = 1; inwidth = 2'b00; nvec = 0; start = 1;
        cyc();
        start = 0;
        for (int n = 0; n < 40; n++) begin
            if (st && t_st < 0) t_st = n;
            if (lst && t_lst < 0) t_lst = n;
            if (res_valid && t_rv < 0) t_rv = n;
            if (done && t_done < 0) t_done = n;
            cyc();
        end
        chk("t1_st", 32'(t_st), 1);
        chk("t1_lst", 32'(t_lst), 8);
        chk("t1_res_valid", 32'(t_rv), 12);
        chk("t1_done", 32'(t_done), 13);

        // Consumer back-pressure in OUT.
        act_valid = 1; res_ready = 0; inwidth = 2'b00; nvec = 8'd1; start = 1;
        cyc();
        start = 0;
        for (int n = 0; n < 100 && !res_valid; n++) cyc();
        chk("t3_reach_out", 32'(res_valid), 1);
        for (int k = 0; k < 5; k++) begin
            chk("t3_res_valid_held", 32'(res_valid), 1);
            chk("t3_no_pop", 32'(act_pop), 0);
            cyc();
        end
        res_ready = 1;
        cyc();
        chk("t3_resume_pop", 32'({busy, res_valid, act_pop}), 32'b101);
        wait_idle("t3_idle");

        // Activation starvation in WAIT_ACT.
        act_valid = 0; start = 1; inwidth = 2'b00; nvec = 0;
        cyc();
        start = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t4_stall", 32'({busy, sel, acc_en, act_pop}), 32'b1_0000_0_0);
            cyc();
        end
        act_valid = 1;
        #1;
        chk("t4_pop", 32'({act_pop, acc_en}), 32'b10);
        cyc();
        chk("t4_compute", 32'({acc_en, st, sel}), 32'b1_1_0000);
        wait_idle("t4_idle");

        // Abort mid-compute.
        start = 1; inwidth = 2'b10; nvec = 8'd3;
        cyc();
        start = 0;
        for (int n = 0; n < 50 && !(acc_en && sel == 4'd5); n++) cyc();
        chk("t5_reach_sel5", 32'(sel), 5);
        abort = 1;
        cyc();
        abort = 0;
        chk("t5_abort_idle", 32'({busy, sel, acc_en, res_valid}), 0);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin if (done || busy) cnt++; cyc(); end
        chk("t5_abort_quiet", 32'(cnt), 0);

        // Start during busy must not reload the configuration.
        start = 1; inwidth = 2'b00; nvec = 0;
        cyc();
        start = 0; b_n = 0; p_n = 0;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (!busy) break;
            b_n++;
            if (act_pop) p_n++;
            if (n == 2) begin start = 1; inwidth = 2'b10; nvec = 8'd3; end
            else start = 0;
            cyc();
        end
        start = 0;
        chk("t5_ignored_start_cycles", 32'(b_n), 13);
        chk("t5_ignored_start_pops", 32'(p_n), 1);
        cyc();
        chk("t5_no_restart", 32'(busy), 0);

        // Reset mid-drain.
        start = 1; inwidth = 2'b00; nvec = 0;
        cyc();
        start = 0;
        for (int n = 0; n < 50 && !lst; n++) cyc();
        cyc();
        chk("t5_in_drain", 32'({busy, acc_en, res_valid}), 32'b100);
        rstn = 0;
        cyc();
        rstn = 1;
        chk("t5_reset_idle", 32'({busy, sel, res_valid, done}), 0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin if (done || res_valid || busy) cnt++; cyc(); end
        chk("t5_reset_quiet", 32'(cnt), 0);

`ifdef CIM_SIGNED_EN
        for (int m = 1; m >= 0; m--) begin
            signed_mode = 1'(m); start = 1; inwidth = 2'b01; nvec = 0; act_valid = 1; res_ready = 1;
            cyc();
            start = 0; signed_mode = 1'(1 - m); cnt = 0; ms = -1;
            for (int n = 0; n < 40; n++) begin
                #1;
                if (msb_neg) begin cnt++; ms = int'(sel); end
                cyc();
            end
            chk($sformatf("t6_msb_neg_count_s%0d", m), 32'(cnt), 32'(m));
            if (m == 1) chk("t6_msb_neg_sel", 32'(ms), 11);
        end
`endif

        // Random traffic, checked cycle by cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            act_valid = ($urandom % 4) != 0;
            res_ready = ($urandom % 3) != 0;
            start     = ($urandom % 6) == 0;
            abort     = ($urandom % 60) == 0;
            rstn      = ($urandom % 300) != 0;
            inwidth   = 2'($urandom);
            nvec      = 8'($urandom % 4);
`ifdef CIM_SIGNED_EN
            signed_mode = 1'($urandom);
`endif
            cyc();
        end
        start = 0; abort = 0; rstn = 1; act_valid = 1; res_ready = 1;
        wait_idle("rand_drain_idle");
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
